ternary_mac_sequencer: RTL and testbench
========================================

// Module: ternary_mac_sequencer
// PURPOSE
// - Command-driven controller for the ternary weight-load / matrix-vector-multiply datapath.
// - Accepts LOAD and MULT commands from the host over a valid/ready handshake.
// - Sequences the weight loader beat-by-beat, then steps the multiplier row index across
//   MAX_OUT_LEN rows per input vector.
// - Flags output beats after the multiplier pipeline delay.
// - Replaces the free-running count/state pair at the top level.
// PARAMETERS
// - MAX_IN_LEN   14  input vector length (sizes the load beat count)
// - MAX_OUT_LEN  7   output rows per vector, 1..8
// - LOAD_BEATS   14  16-bit host beats per full weight load, 1..15
// - PIPE_LAT     1   cycles from mult_en/row to the matching VecOut byte, 0..3
// PORTS
// - clk        in   1  clock
// - rst_n      in   1  synchronous active-low reset
// - cmd_valid  in   1  host command valid
// - cmd_ready  out  1  controller can accept a command (high only in IDLE)
// - cmd_op     in   2  2'b10 = LOAD, 2'b11 = MULT; others illegal
// - cmd_len    in   4  MULT: number of input vectors (0 treated as 1); ignored for LOAD
// - in_valid   in   1  host data beat present on the shared 16-bit input bus
// - load_en    out  1  loader captures the current beat
// - load_idx   out  4  beat index 0..LOAD_BEATS-1 for the loader
// - mult_en    out  1  multiplier active this cycle
// - row        out  3  current weight row 0..MAX_OUT_LEN-1
// - out_valid  out  1  uo_out carries a valid result byte
// - out_last   out  1  with out_valid: last row of the last vector
// - busy       out  1  state != IDLE
// - done       out  1  1-cycle pulse when a command fully completes
// - err        out  1  1-cycle pulse on an illegal or rejected command
// BEHAVIOUR
// - Reset (rst_n=0 at a clk edge):
//   - state=IDLE; all counters 0; wloaded=0.
//   - All outputs 0 except cmd_ready=1.
//   - Reset mid-operation aborts immediately; no done pulse is issued.
// - FSM states: IDLE, LOAD, MULT, DRAIN.
// - IDLE:
//   - A command is accepted when cmd_valid & cmd_ready.
//   - LOAD -> LOAD state, beat counter=0.
//   - MULT -> MULT state, row=0, vectors_left=max(cmd_len,1).
//   - Illegal op -> err pulse next cycle, remain IDLE.
// - LOAD:
//   - load_en = in_valid; load_idx = beat counter.
//   - The counter increments only on in_valid; the host may stall indefinitely.
//   - On the beat with load_idx=LOAD_BEATS-1 and in_valid: set wloaded=1, go to IDLE,
//     and pulse done the same cycle as that beat.
// - MULT:
//   - mult_en=1; row advances every cycle with no stall.
//   - row=MAX_OUT_LEN-1 wraps to 0 and decrements vectors_left.
//   - At the wrap with vectors_left=1, go to DRAIN.
// - DRAIN:
//   - mult_en=0; hold for PIPE_LAT cycles (0 -> skip directly to IDLE).
//   - Then return to IDLE with a done pulse.
// - Output timing:
//   - out_valid = mult_en delayed PIPE_LAT cycles.
//   - out_last = (row==MAX_OUT_LEN-1 & vectors_left==1 & mult_en) delayed PIPE_LAT cycles.
//   - Exactly MAX_OUT_LEN*vectors out_valid beats per MULT command.
// - cmd_valid outside IDLE is ignored: no err, no queueing.
// - done and a new cmd acceptance may share a cycle only when done is issued from IDLE entry;
//   cmd_ready rises the cycle after done.
// - Widths: vectors_left is 4 bits; beat counter 4 bits; row 3 bits.
//   No counter ever exceeds its stated range.
// CONFIGURATION
// - TTSEQ_WLOCK_EN defined:
//   - A MULT command with wloaded=0 is rejected: err pulse, remain IDLE.
//   - wloaded clears on reset only.
// - TTSEQ_WLOCK_EN undefined:
//   - MULT is always accepted (weights undefined until loaded).
//   - wloaded is still tracked but unused.
// TESTING
// - Reset, then LOAD with in_valid always 1 -> load_idx 0..13 on consecutive cycles,
//   done on the 14th beat, busy low the next cycle.
// - LOAD with in_valid toggling 1,0,1,0 -> load_en only on the high cycles;
//   done after 14 accepted beats (27 cycles).
// - MULT cmd_len=2, PIPE_LAT=1 -> row 0..6,0..6; 14 out_valid beats starting 1 cycle after
//   mult_en; out_last only on the 14th; done 1 cycle after it.
// - MULT cmd_len=0 -> identical to cmd_len=1: 7 beats, out_last on row 6.
// - cmd_op=2'b01 in IDLE -> err pulse, state stays IDLE;
//   cmd_valid during MULT -> ignored, no err.
// - rst_n low at MULT row 3 -> next cycle IDLE, no done, out_valid 0;
//   with TTSEQ_WLOCK_EN a following MULT -> err.

Source files
------------

// File: rtl/ternary_mac_sequencer_if.sv
// ----------------------------------------------------------------------------
// ternary_mac_sequencer_if
// Host command / data-beat handshake and datapath control bundle for
// ternary_mac_sequencer. Carries no clock or reset.
//
// Signals
//   cmd_valid  host -> seq   command valid
//   cmd_ready  seq  -> host  command can be accepted (IDLE only)
//   cmd_op     host -> seq   2'b10 LOAD, 2'b11 MULT, others illegal
//   cmd_len    host -> seq   MULT vector count (0 behaves as 1)
//   in_valid   host -> seq   data beat present on the shared input bus
//   load_en    seq  -> dp    loader captures the current beat
//   load_idx   seq  -> dp    beat index for the loader
//   mult_en    seq  -> dp    multiplier active
//   row        seq  -> dp    current weight row
//   out_valid  seq  -> host  result byte valid
//   out_last   seq  -> host  last row of last vector
//   busy       seq  -> host  controller not idle
//   done       seq  -> host  command complete pulse
//   err        seq  -> host  illegal / rejected command pulse
//
// Modports: master = host side, slave = sequencer side.
// ----------------------------------------------------------------------------
interface ternary_mac_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_len;
    logic       in_valid;
    logic       load_en;
    logic [3:0] load_idx;
    logic       mult_en;
    logic [2:0] row;
    logic       out_valid;
    logic       out_last;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output cmd_valid, cmd_op, cmd_len, in_valid,
        input  cmd_ready, load_en, load_idx, mult_en, row,
               out_valid, out_last, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, in_valid,
        output cmd_ready, load_en, load_idx, mult_en, row,
               out_valid, out_last, busy, done, err
    );
endinterface

// File: rtl/ternary_mac_sequencer.sv
// ----------------------------------------------------------------------------
// ternary_mac_sequencer
// Command-driven controller for the ternary weight-load / matrix-vector
// multiply datapath. LOAD steps the weight loader through LOAD_BEATS host
// beats (stallable via in_valid). MULT sweeps the row index across
// MAX_OUT_LEN rows for each of cmd_len input vectors, then drains the
// multiplier pipeline. out_valid/out_last follow mult_en by PIPE_LAT cycles.
//
// Ports
//   clk    clock
//   rst_n  synchronous active-low reset
//   bus    ternary_mac_sequencer_if.slave (command, data-beat and control)
//
// Parameters
//   MAX_IN_LEN   input vector length (informational; sizes LOAD_BEATS)
//   MAX_OUT_LEN  rows per vector, 1..8
//   LOAD_BEATS   host beats per full weight load, 1..15
//   PIPE_LAT     multiplier latency to the matching output byte, 0..3
//
// Optional feature macro: TTSEQ_WLOCK_EN
//   When defined, a MULT issued before any completed LOAD is rejected with
//   an err pulse. When undefined, MULT is always accepted.
// ----------------------------------------------------------------------------
module ternary_mac_sequencer #(
    parameter int MAX_IN_LEN  = 14,
    parameter int MAX_OUT_LEN = 7,
    parameter int LOAD_BEATS  = 14,
    parameter int PIPE_LAT    = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    ternary_mac_sequencer_if.slave      bus
);

    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_MULT = 2'b11;

    localparam logic [3:0] BEAT_LAST  = 4'(LOAD_BEATS - 1);
    localparam logic [2:0] ROW_LAST   = 3'(MAX_OUT_LEN - 1);
    localparam int         DRAIN_END  = (PIPE_LAT > 0) ? PIPE_LAT - 1 : 0;
    localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_END);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_MULT,
        S_DRAIN
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] beat_q, beat_d;
    logic [2:0] row_q, row_d;
    logic [3:0] vec_q, vec_d;       // vectors still to process, incl. current
    logic [1:0] drain_q, drain_d;
    logic       wloaded_q, wloaded_d;
    logic       done_q, done_d;     // MULT completion, seen on IDLE entry
    logic       err_q, err_d;

    logic       mult_ok;
    logic       load_done;
    logic       raw_valid;
    logic       raw_last;

`ifdef TTSEQ_WLOCK_EN
    assign mult_ok = wloaded_q;
`else
    assign mult_ok = 1'b1;
`endif

    // NOTE: state registers use non-blocking assignments and a reset branch
    // sampled only on the clock edge, so reset is fully synchronous.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            beat_q    <= '0;
            row_q     <= '0;
            vec_q     <= '0;
            drain_q   <= '0;
            wloaded_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            row_q     <= row_d;
            vec_q     <= vec_d;
            drain_q   <= drain_d;
            wloaded_q <= wloaded_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        row_d     = row_q;
        vec_d     = vec_q;
        drain_d   = drain_q;
        wloaded_d = wloaded_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_op == OP_LOAD) begin
                        state_d = S_LOAD;
                        beat_d  = '0;
                    end else if (bus.cmd_op == OP_MULT && mult_ok) begin
                        state_d = S_MULT;
                        row_d   = '0;
                        vec_d   = (bus.cmd_len == 4'd0) ? 4'd1 : bus.cmd_len;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_LOAD: begin
                if (bus.in_valid) begin
                    if (beat_q == BEAT_LAST) begin
                        state_d   = S_IDLE;
                        beat_d    = '0;
                        wloaded_d = 1'b1;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end

            S_MULT: begin
                if (row_q == ROW_LAST) begin
                    row_d = '0;
                    if (vec_q == 4'd1) begin
                        vec_d = '0;
                        if (PIPE_LAT == 0) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_DRAIN;
                            drain_d = '0;
                        end
                    end else begin
                        vec_d = vec_q - 4'd1;
                    end
                end else begin
                    row_d = row_q + 3'd1;
                end
            end

            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_IDLE;
                    drain_d = '0;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // LOAD completion is flagged combinationally on the final accepted beat;
    // MULT completion is registered so it appears on the first IDLE cycle.
    assign load_done = (state_q == S_LOAD) && bus.in_valid && (beat_q == BEAT_LAST);

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.load_en   = (state_q == S_LOAD) && bus.in_valid;
    assign bus.load_idx  = beat_q;
    assign bus.mult_en   = (state_q == S_MULT);
    assign bus.row       = row_q;
    assign bus.done      = load_done | done_q;
    assign bus.err       = err_q;

    assign raw_valid = (state_q == S_MULT);
    assign raw_last  = raw_valid && (row_q == ROW_LAST) && (vec_q == 4'd1);

    // Align the output flags with the multiplier pipeline.
    generate
        if (PIPE_LAT == 0) begin : g_no_pipe
            assign bus.out_valid = raw_valid;
            assign bus.out_last  = raw_last;
        end else begin : g_pipe
            logic [PIPE_LAT-1:0] valid_pipe;
            logic [PIPE_LAT-1:0] last_pipe;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    valid_pipe <= '0;
                    last_pipe  <= '0;
                end else begin
                    valid_pipe[0] <= raw_valid;
                    last_pipe[0]  <= raw_last;
                    for (int i = 1; i < PIPE_LAT; i++) begin
                        valid_pipe[i] <= valid_pipe[i-1];
                        last_pipe[i]  <= last_pipe[i-1];
                    end
                end
            end

            assign bus.out_valid = valid_pipe[PIPE_LAT-1];
            assign bus.out_last  = last_pipe[PIPE_LAT-1];
        end
    endgenerate

endmodule

// File: tb/tb_ternary_mac_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ternary_mac_sequencer
// Scoreboard bench for ternary_mac_sequencer (default parameters,
// PIPE_LAT = 1). Stimulus pushes expected loader beats, multiplier rows,
// output beats and done/err events into queues; a negedge monitor pops and
// compares whenever the DUT presents the matching output.
// ----------------------------------------------------------------------------
module tb_ternary_mac_sequencer;

    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_MULT = 2'b11;
    localparam logic [1:0] OP_BAD  = 2'b01;
    localparam int EV_DONE = 1;
    localparam int EV_ERR  = 2;

    typedef struct packed {
        logic [3:0] idx;
        logic       done;
    } load_exp_t;

    logic clk;
    logic rst_n;

    ternary_mac_sequencer_if bus ();

    ternary_mac_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    load_exp_t q_load[$];
    int        q_row[$];
    bit        q_out[$];
    int        q_evt[$];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic fail(input string name, input int actual);
        checks++;
        errors++;
        $display("FAIL %s: got %0d with no expectation queued (t=%0t)", name, actual, $time);
    endtask

    // ---------------- monitor ----------------
    logic prev_mult;
    logic prev_last;
    initial begin
        prev_mult = 1'b0;
        prev_last = 1'b0;
    end

    always @(negedge clk) begin
        if (bus.load_en) begin
            if (q_load.size() == 0) fail("load_unexpected", int'(bus.load_idx));
            else begin
                load_exp_t e;
                e = q_load.pop_front();
                check("load_idx", int'(bus.load_idx), int'(e.idx));
                check("load_done", int'(bus.done), int'(e.done));
            end
        end
        if (bus.mult_en) begin
            if (q_row.size() == 0) fail("row_unexpected", int'(bus.row));
            else check("row", int'(bus.row), q_row.pop_front());
        end
        if (bus.out_valid) begin
            if (q_out.size() == 0) fail("out_unexpected", int'(bus.out_last));
            else check("out_last", int'(bus.out_last), int'(q_out.pop_front()));
        end else if (bus.out_last) begin
            fail("out_last_without_valid", 1);
        end
        if (bus.done && !bus.load_en) begin
            if (q_evt.size() == 0) fail("done_unexpected", EV_DONE);
            else check("evt_done", EV_DONE, q_evt.pop_front());
        end
        if (bus.err) begin
            if (q_evt.size() == 0) fail("err_unexpected", EV_ERR);
            else check("evt_err", EV_ERR, q_evt.pop_front());
        end
        // One-cycle pipeline: out_valid trails mult_en, done trails out_last.
        if (bus.out_valid || prev_mult) check("out_valid_lat", int'(bus.out_valid), int'(prev_mult));
        if (prev_last) check("done_after_last", int'(bus.done), 1);
        prev_mult = rst_n ? bus.mult_en : 1'b0;
        prev_last = rst_n ? bus.out_last : 1'b0;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [3:0] len);
        check("cmd_ready_before_issue", int'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_len   = len;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_len   = 4'd0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (bus.busy && n < limit) begin
            tick();
            n++;
        end
        if (bus.busy) fail("wait_idle_timeout", n);
    endtask

    task automatic push_load();
        for (int i = 0; i < 14; i++) begin
            load_exp_t e;
            e.idx  = 4'(i);
            e.done = (i == 13);
            q_load.push_back(e);
        end
    endtask

    task automatic push_mult(input int vectors);
        for (int v = 0; v < vectors; v++) begin
            for (int r = 0; r < 7; r++) begin
                q_row.push_back(r);
                q_out.push_back((v == vectors - 1) && (r == 6));
            end
        end
        q_evt.push_back(EV_DONE);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_len   = 4'd0;
        bus.in_valid  = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_cmd_ready", int'(bus.cmd_ready), 1);
        check("rst_busy",      int'(bus.busy),      0);
        check("rst_load_en",   int'(bus.load_en),   0);
        check("rst_load_idx",  int'(bus.load_idx),  0);
        check("rst_mult_en",   int'(bus.mult_en),   0);
        check("rst_row",       int'(bus.row),       0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_done",      int'(bus.done),      0);
        check("rst_err",       int'(bus.err),       0);
        rst_n = 1'b1;
        tick();

        // LOAD, in_valid held high: 14 consecutive beats, done on the last.
        push_load();
        issue(OP_LOAD, 4'd0);
        bus.in_valid = 1'b1;
        repeat (13) tick();
        check("load_busy_before_last", int'(bus.busy), 1);
        tick();
        bus.in_valid = 1'b0;
        check("load_idle_after_done", int'(bus.busy), 0);
        tick();

        // LOAD, in_valid toggling: 14 beats across 27 cycles.
        push_load();
        issue(OP_LOAD, 4'd0);
        for (int k = 0; k < 27; k++) begin
            bus.in_valid = (k % 2 == 0);
            tick();
            if (k == 25) check("toggle_busy_at_26", int'(bus.busy), 1);
        end
        bus.in_valid = 1'b0;
        check("toggle_idle_after_27", int'(bus.busy), 0);
        tick();

        // MULT cmd_len=2, with a stray illegal command mid-operation.
        push_mult(2);
        issue(OP_MULT, 4'd2);
        repeat (3) tick();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_BAD;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        check("mult_busy_ignores_cmd", int'(bus.busy), 1);
        wait_idle(40);
        repeat (2) tick();

        // MULT cmd_len=0 behaves as one vector.
        push_mult(1);
        issue(OP_MULT, 4'd0);
        wait_idle(20);
        repeat (2) tick();

        // Illegal opcode in IDLE.
        q_evt.push_back(EV_ERR);
        issue(OP_BAD, 4'd0);
        check("illegal_stays_idle", int'(bus.busy), 0);
        check("illegal_cmd_ready",  int'(bus.cmd_ready), 1);
        repeat (2) tick();

        // Reset during MULT row 3: no done, outputs cleared.
        for (int r = 0; r < 4; r++) q_row.push_back(r);
        for (int r = 0; r < 3; r++) q_out.push_back(1'b0);
        issue(OP_MULT, 4'd1);
        repeat (3) tick();
        check("abort_row_before_reset", int'(bus.row), 3);
        rst_n = 1'b0;
        tick();
        check("abort_busy",      int'(bus.busy),      0);
        check("abort_cmd_ready", int'(bus.cmd_ready), 1);
        check("abort_out_valid", int'(bus.out_valid), 0);
        check("abort_done",      int'(bus.done),      0);
        rst_n = 1'b1;
        tick();

        // MULT after reset: weights no longer loaded.
`ifdef TTSEQ_WLOCK_EN
        q_evt.push_back(EV_ERR);
`else
        push_mult(1);
`endif
        issue(OP_MULT, 4'd1);
        wait_idle(20);
        repeat (3) tick();

        check("q_load_empty", q_load.size(), 0);
        check("q_row_empty",  q_row.size(),  0);
        check("q_out_empty",  q_out.size(),  0);
        check("q_evt_empty",  q_evt.size(),  0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
